chmem_stream_reader: RTL and testbench

CHMEM_STREAM_READER -- requirements
Module: chmem_stream_reader

---
 rtl/chmem_stream_reader.sv | 118 +++++++++++
 tb/tb_chmem_stream_reader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/chmem_stream_reader.sv
// chmem_stream_reader: reads a burst of 16-bit words from a byte-addressed
// memory bank and streams them out high byte first over a valid/ready port.
module chmem_stream_reader #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_index,
  input  logic [4:0]        word_count,
  output logic [ADDR_W-1:0] mem_index,
  input  logic [WORD_W-1:0] mem_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W  = 5;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND_HI,
    SEND_LO,
    DONE
  } state_t;

  state_t              state;
  logic [BYTE_W-1:0]   word_lo_q;    // low byte of the fetched word; high byte sits in tx_data
  logic [CNT_W-1:0]    remaining_q;  // words still to send, including the current one
  logic                xfer_c;

  // A byte leaves the block when both sides agree on a rising edge.
  assign xfer_c = tx_valid & tx_ready;

  // Burst sequencer; mem_index is the index register itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mem_index   <= '0;
      word_lo_q   <= '0;
      remaining_q <= '0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      tx_last     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (word_count != '0) begin
              // Word-aligned start: bit 0 of the byte index is forced low.
              mem_index   <= base_index & ~ADDR_W'(1);
              remaining_q <= word_count;
              state       <= FETCH;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end

        FETCH: begin
          tx_data   <= mem_data[WORD_W-1 -: BYTE_W];
          word_lo_q <= mem_data[BYTE_W-1:0];
          tx_valid  <= 1'b1;
          tx_last   <= 1'b0;
          state     <= SEND_HI;
        end

        SEND_HI: begin
          if (xfer_c) begin
            tx_data <= word_lo_q;
            tx_last <= (remaining_q == CNT_W'(1));
            state   <= SEND_LO;
          end
        end

        SEND_LO: begin
          if (xfer_c) begin
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
            if (remaining_q == CNT_W'(1)) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              // Index wraps naturally at the bank size.
              mem_index   <= mem_index + ADDR_W'(2);
              remaining_q <= remaining_q - CNT_W'(1);
              state       <= FETCH;
            end
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          tx_valid <= 1'b0;
          tx_last  <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chmem_stream_reader.sv
// Self-checking bench for chmem_stream_reader: table of bursts plus
// hand-written abort and start-while-busy sequences, scored against a byte queue.
module tb_chmem_stream_reader;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned WORD_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_index;
  logic [4:0]        word_count;
  logic [ADDR_W-1:0] mem_index;
  logic [WORD_W-1:0] mem_data;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_last;
  logic              busy;
  logic              done;

  logic [7:0] mem [64];

  always #5 clk = ~clk;

  assign mem_data = {mem[mem_index], mem[mem_index + 6'd1]};

  chmem_stream_reader #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_index (base_index),
    .word_count (word_count),
    .mem_index  (mem_index),
    .mem_data   (mem_data),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_last    (tx_last),
    .busy       (busy),
    .done       (done)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  typedef struct {
    logic [5:0] base;
    logic [4:0] count;
    int         mode;       // 0 ready high, 1 toggle, 2 random, 3 manual
    int         first_idx;
    int         exp_bytes;
  } vec_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   xfer_cnt = 0;
  int   done_cnt = 0;
  int   ready_mode = 0;

  logic       stall_q = 1'b0;
  logic [7:0] stall_data = '0;
  logic       stall_last = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected byte stream of a burst, built from the bench's memory image.
  task automatic push_model(input logic [5:0] b, input logic [4:0] c);
    logic [5:0] idx;
    exp_t       e;
    idx = b & 6'b111110;
    for (int w = 0; w < int'(c); w++) begin
      e.data = mem[idx];        e.last = 1'b0;                   exp_q.push_back(e);
      e.data = mem[idx + 6'd1]; e.last = (w == int'(c) - 1);     exp_q.push_back(e);
      idx = idx + 6'd2;
    end
  endtask

  // Ready pattern generator.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: tx_ready = 1'b1;
      1: tx_ready = ~tx_ready;
      2: tx_ready = 1'($urandom_range(0, 1));
      default: ;
    endcase
  end

  // Output monitor: scores transfers, stall stability and done pulses.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (stall_q && tx_valid) begin
      check("stall_data_stable", tx_data, stall_data);
      check("stall_last_stable", tx_last, stall_last);
    end
    stall_q    = tx_valid && !tx_ready;
    stall_data = tx_data;
    stall_last = tx_last;
    if (tx_valid && tx_ready) begin
      xfer_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte: got %0h, expected no transfer (t=%0t)", tx_data, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("tx_data", tx_data, e.data);
        check("tx_last", tx_last, e.last);
      end
    end
  end

  task automatic wait_idle(input string name, input int x0, input int d0, input int bytes);
    int n;
    n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: busy still 1, expected 0 within 3000 cycles", name);
    end
    @(negedge clk);
    check({name, "_bytes"}, xfer_cnt - x0, bytes);
    check({name, "_done_pulses"}, done_cnt - d0, 1);
    check({name, "_queue_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic run_burst(input vec_t v);
    int x0, d0;
    @(posedge clk); #1;
    ready_mode = v.mode;
    push_model(v.base, v.count);
    x0 = xfer_cnt;
    d0 = done_cnt;
    base_index = v.base;
    word_count = v.count;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("busy_after_start", busy, 1);
    check("valid_in_first_cycle", tx_valid, 0);
    if (v.count != 0) check("first_mem_index", mem_index, v.first_idx);
    else              check("done_zero_count", done, 1);
    @(negedge clk);
    check("valid_second_cycle", tx_valid, int'(v.count != 0));
    if (v.count == 0) begin
      check("busy_one_cycle", busy, 0);
      check("done_one_cycle", done, 0);
    end
    wait_idle("burst", x0, d0, v.exp_bytes);
  endtask

  vec_t vecs[7];

  initial begin
    int x0, d0, n;
    vec_t v;

    vecs[0] = '{base: 6'd0,  count: 5'd2,  mode: 0, first_idx: 0,  exp_bytes: 4};
    vecs[1] = '{base: 6'd0,  count: 5'd2,  mode: 1, first_idx: 0,  exp_bytes: 4};
    vecs[2] = '{base: 6'd62, count: 5'd2,  mode: 0, first_idx: 62, exp_bytes: 4};
    vecs[3] = '{base: 6'd0,  count: 5'd0,  mode: 0, first_idx: 0,  exp_bytes: 0};
    vecs[4] = '{base: 6'd5,  count: 5'd3,  mode: 2, first_idx: 4,  exp_bytes: 6};
    vecs[5] = '{base: 6'd20, count: 5'd31, mode: 2, first_idx: 20, exp_bytes: 62};
    vecs[6] = '{base: 6'd63, count: 5'd1,  mode: 1, first_idx: 62, exp_bytes: 2};

    for (int i = 0; i < 64; i++) mem[i] = 8'(i * 37 + 11);
    mem[0]  = 8'h12; mem[1]  = 8'h34; mem[2] = 8'hAB; mem[3] = 8'hCD;
    mem[62] = 8'hE1; mem[63] = 8'h7F;

    rst = 1'b1; start = 1'b0; base_index = '0; word_count = '0; tx_ready = 1'b1;
    @(negedge clk);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_last", tx_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_mem_index", mem_index, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_burst(vecs[i]);

    // Reset after the first byte of a 3-word burst aborts it outright.
    @(posedge clk); #1;
    ready_mode = 0;
    push_model(6'd0, 5'd3);
    x0 = xfer_cnt; d0 = done_cnt;
    base_index = 6'd0; word_count = 5'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (xfer_cnt == x0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("abort_first_byte_seen", xfer_cnt - x0, 1);
    #1;
    rst = 1'b1;
    #1;
    check("abort_tx_valid", tx_valid, 0);
    check("abort_busy", busy, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("abort_quiet_valid", tx_valid, 0);
    end
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_byte_count", xfer_cnt - x0, 1);
    v = '{base: 6'd10, count: 5'd3, mode: 0, first_idx: 10, exp_bytes: 6};
    run_burst(v);

    // start pulsed while in SEND_LO must not disturb the burst.
    @(posedge clk); #1;
    ready_mode = 3;
    tx_ready   = 1'b0;
    push_model(6'd0, 5'd2);
    x0 = xfer_cnt; d0 = done_cnt;
    base_index = 6'd0; word_count = 5'd2; start = 1'b1;
    @(posedge clk); #1;           // FETCH
    start = 1'b0;
    @(posedge clk); #1;           // SEND_HI, stalled
    tx_ready = 1'b1;
    @(posedge clk); #1;           // high byte taken, SEND_LO
    tx_ready   = 1'b0;
    start      = 1'b1;
    base_index = 6'd40;
    word_count = 5'd5;
    @(negedge clk);
    check("busy_start_ignored", busy, 1);
    @(posedge clk); #1;
    start      = 1'b0;
    ready_mode = 0;
    wait_idle("busy_start", x0, d0, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
